// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state type and pipeline-register control encodings
package hazard_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // Control bundle driven onto the PC, IF/ID, ID/EX and EX/MEM registers
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
        logic exmem_en;
        logic exmem_bubble;
    } hz_ctrl_t;

    // Register x0 is hard-wired zero and never creates a dependency
    localparam logic [4:0] REG_X0 = 5'd0;

    // NOP fill: PC held, every downstream register loads a NOP/bubble
    localparam hz_ctrl_t CTRL_FILL = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                       idex_en: 1'b1, idex_bubble: 1'b1,
                                       exmem_en: 1'b1, exmem_bubble: 1'b1};

    // Normal flow: everything advances, nothing squashed
    localparam hz_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                      idex_en: 1'b1, idex_bubble: 1'b0,
                                      exmem_en: 1'b1, exmem_bubble: 1'b0};

    // Whole pipeline frozen while data memory is busy
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                         idex_en: 1'b0, idex_bubble: 1'b0,
                                         exmem_en: 1'b0, exmem_bubble: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use comparator between the ID sources and the EX load destination
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_to_reg,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard_o = ex_mem_to_reg && ex_reg_write && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FILL_CYCLES = 4,
    parameter int MAX_WAIT    = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FW = $clog2(FILL_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

    hz_state_t        state_q, state_d;
    logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    hz_ctrl_t         ctrl;
    logic             load_use;
    logic             mem_busy;

    load_use_detect u_load_use_detect (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .hazard_o      (load_use)
    );

    assign mem_busy = mem_req && !mem_ready;

    // Next state and Mealy control outputs; memory wait beats branch beats load-use
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        ctrl       = CTRL_RUN;
        case (state_q)
            FILL: begin
                ctrl       = CTRL_FILL;
                fill_cnt_d = fill_cnt_q + FW'(1);
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mem_busy) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WW'(1);
                end else if (ex_branch_taken) begin
                    // Squash the two younger instructions; a pending load-use is moot
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.ifid_en     = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt_q == WAIT_MAX) begin
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
            end
            default: begin
                ctrl    = CTRL_FILL;
                state_d = FILL;
            end
        endcase
        if (rst) begin
            ctrl = CTRL_FILL;
        end
    end

    // Saturating performance counters; FILL cycles are never counted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != FILL) && !ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((state_q == RUN) && ctrl.ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, counter and sticky-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_en     = ctrl.exmem_en;
    assign exmem_bubble = ctrl.exmem_bubble;
    assign mem_timeout  = timeout_q;
    assign stall_count  = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int FILL = 4;
    localparam int MAXW = 4;
    localparam int CW   = 32;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble}
    localparam logic [6:0] P_FILL   = 7'b0111111;
    localparam logic [6:0] P_RUN    = 7'b1101010;
    localparam logic [6:0] P_BRANCH = 7'b1111110;
    localparam logic [6:0] P_LU     = 7'b0001110;
    localparam logic [6:0] P_FREEZE = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_to_reg;
    logic          ex_branch_taken, mem_req, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en;
    logic          ifid_flush, idex_bubble, exmem_bubble, mem_timeout;
    logic [CW-1:0] stall_count, flush_count;
    wire  [6:0]    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble};

    int vectors = 0;
    int errors  = 0;

    // Reference model: remaining fill cycles, waiting flag, elapsed wait cycles, counters
    int      m_fill;
    bit      m_wait;
    int      m_wcnt;
    longint  m_stall;
    longint  m_flush;
    bit      m_tmo;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .FILL_CYCLES (FILL),
        .MAX_WAIT    (MAXW),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    function automatic bit lu_hazard();
        return ex_mem_to_reg && ex_reg_write && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [6:0] exp_ctrl();
        if (rst || m_fill > 0)        return P_FILL;
        if (m_wait)                   return mem_ready ? P_RUN : P_FREEZE;
        if (mem_req && !mem_ready)    return P_FREEZE;
        if (ex_branch_taken)          return P_BRANCH;
        if (lu_hazard())              return P_LU;
        return P_RUN;
    endfunction

    function automatic logic [CW-1:0] sat(input longint v);
        longint top = (longint'(1) << CW) - 1;
        return (v > top) ? CW'(top) : CW'(v);
    endfunction

    // Advance the model by one clock using the inputs now applied, then clock the DUT
    task automatic step();
        bit pc_stall;
        pc_stall = (exp_ctrl()[6] == 1'b0);
        if (rst) begin
            m_fill = FILL; m_wait = 0; m_wcnt = 0;
            m_stall = 0; m_flush = 0; m_tmo = 0;
        end else if (m_fill > 0) begin
            m_fill--;
        end else if (m_wait) begin
            if (mem_ready) begin
                m_wait = 0;
            end else begin
                m_stall++;
                if (m_wcnt >= MAXW) m_tmo = 1;
                m_wcnt++;
            end
        end else begin
            if (mem_req && !mem_ready) begin
                m_wait = 1; m_wcnt = 1;
            end else if (ex_branch_taken) begin
                m_flush++;
            end
            if (pc_stall) m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 5'd0; ex_reg_write = 0; ex_mem_to_reg = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = rd;
        id_rs1 = 5'd3; id_uses_rs1 = 1; id_rs2 = 5'd5; id_uses_rs2 = 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (act !== P_FILL) begin
                errors++; $display("FAIL reset_hold ctrl: got %b want %b", act, P_FILL);
            end
            step();
        end
        rst = 0;
        #1;
        for (int i = 0; i < FILL; i++) begin
            vectors++;
            if (act !== P_FILL || act !== exp_ctrl()) begin
                errors++; $display("FAIL fill[%0d] ctrl: got %b want %b", i, act, P_FILL);
            end
            step();
        end
        vectors++;
        if (act !== P_RUN || stall_count !== '0 || flush_count !== '0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL after_fill: ctrl %b stall %0d flush %0d tmo %b want %b 0 0 0",
                     act, stall_count, flush_count, mem_timeout, P_RUN);
        end
    endtask

    task automatic test_load_use();
        set_load_use(5'd5);
        vectors++;
        if (act !== P_LU) begin
            errors++; $display("FAIL load_use ctrl: got %b want %b", act, P_LU);
        end
        step();
        idle_inputs();
        vectors++;
        if (act !== P_RUN || stall_count !== 32'd1 || stall_count !== sat(m_stall)) begin
            errors++; $display("FAIL load_use after: ctrl %b stall %0d want %b 1", act, stall_count, P_RUN);
        end
        set_load_use(5'd0);
        vectors++;
        if (act !== P_RUN) begin
            errors++; $display("FAIL load_use_x0 ctrl: got %b want %b", act, P_RUN);
        end
        step();
        idle_inputs();
        vectors++;
        if (stall_count !== 32'd1) begin
            errors++; $display("FAIL load_use_x0 stall: got %0d want 1", stall_count);
        end
    endtask

    task automatic test_branch();
        ex_branch_taken = 1;
        #1;
        vectors++;
        if (act !== P_BRANCH) begin
            errors++; $display("FAIL branch ctrl: got %b want %b", act, P_BRANCH);
        end
        step();
        idle_inputs();
        vectors++;
        if (flush_count !== 32'd1 || flush_count !== sat(m_flush)) begin
            errors++; $display("FAIL branch flush_count: got %0d want 1", flush_count);
        end
    endtask

    task automatic test_branch_and_load_use();
        set_load_use(5'd5);
        ex_branch_taken = 1;
        #1;
        vectors++;
        if (act !== P_BRANCH) begin
            errors++; $display("FAIL branch_lu ctrl: got %b want %b", act, P_BRANCH);
        end
        step();
        idle_inputs();
        vectors++;
        if (stall_count !== 32'd1 || flush_count !== 32'd2) begin
            errors++; $display("FAIL branch_lu counters: stall %0d flush %0d want 1 2", stall_count, flush_count);
        end
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ready = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (act !== P_FREEZE) begin
                errors++; $display("FAIL mem_wait[%0d] ctrl: got %b want %b", i, act, P_FREEZE);
            end
            step();
        end
        mem_ready = 1;
        #1;
        vectors++;
        if (act !== P_RUN) begin
            errors++; $display("FAIL mem_wait release ctrl: got %b want %b", act, P_RUN);
        end
        step();
        idle_inputs();
        vectors++;
        if (stall_count !== 32'd4 || mem_timeout !== 1'b0 || act !== P_RUN) begin
            errors++; $display("FAIL mem_wait after: stall %0d tmo %b ctrl %b want 4 0 %b",
                               stall_count, mem_timeout, act, P_RUN);
        end
    endtask

    task automatic test_timeout();
        mem_req = 1; mem_ready = 0;
        #1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (act !== P_FREEZE || mem_timeout !== m_tmo) begin
                errors++; $display("FAIL timeout[%0d]: ctrl %b tmo %b want %b %b", i, act, mem_timeout, P_FREEZE, m_tmo);
            end
            step();
        end
        mem_ready = 1;
        #1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem_timeout !== 1'b1 || act !== P_RUN) begin
                errors++; $display("FAIL timeout sticky[%0d]: tmo %b ctrl %b want 1 %b", i, mem_timeout, act, P_RUN);
            end
            step();
        end
        rst = 1;
        #1;
        step();
        rst = 0;
        #1;
        vectors++;
        if (mem_timeout !== 1'b0 || stall_count !== '0 || flush_count !== '0 || act !== P_FILL) begin
            errors++; $display("FAIL timeout clear: tmo %b stall %0d flush %0d ctrl %b want 0 0 0 %b",
                               mem_timeout, stall_count, flush_count, act, P_FILL);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_mem_to_reg   = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = ($urandom_range(0, 4) == 0);
            mem_ready       = ($urandom_range(0, 2) != 0);
            #1;
            vectors++;
            if (act !== exp_ctrl() || stall_count !== sat(m_stall) ||
                flush_count !== sat(m_flush) || mem_timeout !== m_tmo) begin
                errors++;
                $display("FAIL random[%0d]: ctrl %b stall %0d flush %0d tmo %b want %b %0d %0d %b",
                         i, act, stall_count, flush_count, mem_timeout,
                         exp_ctrl(), sat(m_stall), sat(m_flush), m_tmo);
            end
            step();
        end
    endtask

    initial begin
        m_fill = FILL; m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_branch_and_load_use();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. After reset it runs a NOP-fill sequence, because the pipeline registers themselves have no reset.

## Interface
Parameters:
- FILL_CYCLES, 4: bubble-fill cycles after reset (≥1).
- MAX_WAIT, 16: memory-wait cycles before the timeout flag sets (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_reg_write, ex_mem_to_reg  in  1  EX instruction writes rd / is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM stage holds a load/store.
- mem_ready  in  1  data memory completes this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1  register load enables.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble, exmem_bubble  out  1  ID/EX / EX/MEM load a NOP (control bits cleared).
- mem_timeout  out  1  sticky error flag.
- stall_count, flush_count  out  CNT_W  saturating performance counters.

## Operation
- FSM states: FILL, RUN, MEM_WAIT. State, counters and flag are registered. Control outputs are combinational from state and inputs (Mealy).
- FILL:
  - Outputs: pc_en=0; ifid_en=1, ifid_flush=1; idex_en=1, idex_bubble=1; exmem_en=1, exmem_bubble=1.
  - fill_cnt increments each cycle.
  - When fill_cnt==FILL_CYCLES-1, go to RUN.
- RUN: all enables are 1 and all flush/bubble signals are 0, except the following, in priority order:
  1. Memory wait (mem_req && !mem_ready):
     - pc_en=ifid_en=idex_en=exmem_en=0; exmem_bubble=0.
     - Go to MEM_WAIT; wait_cnt=1.
  2. Taken branch (ex_branch_taken):
     - pc_en=1; ifid_flush=1; idex_bubble=1.
     - flush_count += 1.
  3. Load-use hazard:
     - Condition: ex_mem_to_reg && ex_reg_write && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
     - pc_en=0; ifid_en=0; idex_bubble=1.
- MEM_WAIT:
  - All enables are 0.
  - On mem_ready: go to RUN; that cycle has all enables =1.
  - Otherwise wait_cnt increments, saturating at MAX_WAIT. When wait_cnt reaches MAX_WAIT, mem_timeout sets and stays set until rst; the FSM keeps waiting.
- A taken branch held in EX during MEM_WAIT is frozen (idex_en=0). It re-presents and is flushed normally after the wait ends.
- Branch plus load-use in the same cycle: branch wins, no stall. The ID instruction is discarded anyway.
- stall_count increments in every RUN or MEM_WAIT cycle with pc_en==0. Neither counter counts during FILL. Both saturate at all-ones.

## Timing
- Reset values: state=FILL, fill_cnt=0, wait_cnt=0, mem_timeout=0, stall_count=0, flush_count=0.
- While rst=1, outputs take the FILL values.
- rst asserted mid-MEM_WAIT or mid-stall: the next cycle is FILL and the counters clear.
- Control outputs respond in the same cycle as the hazard inputs (zero latency). State changes take effect on the next posedge clk.
- Load-use costs exactly 1 stall cycle. On the following cycle EX holds a bubble, so the hazard condition clears.
- Taken branch costs 2 squashed instructions (IF/ID and ID/EX).
- A memory wait of N cycles with mem_ready on the Nth adds N-1 cycles to stall_count.
- Counter and flag updates are visible one cycle after the event.

## Structure
- hazard_pkg holds:
  - typedef enum logic [1:0] {FILL, RUN, MEM_WAIT} hz_state_t.
  - The NOP/bubble encoding constants shared with the pipeline registers.
- One combinational sub-module, load_use_detect, contains the rd/rs comparator and x0 exclusion. Everything else lives in the top.

## Test plan
- Reset fill: assert rst 2 cycles, release → 4 cycles of pc_en=0 with ifid_flush=idex_bubble=exmem_bubble=1, then RUN with all enables=1 and counters at 0.
- Load-use:
  - ex_mem_to_reg=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_en=0, ifid_en=0, idex_bubble=1; stall_count=1.
  - Repeat with ex_rd=0 → no stall.
- Branch: ex_branch_taken=1 in RUN → ifid_flush=1, idex_bubble=1, pc_en=1; flush_count=1.
- Simultaneous branch and load-use → flush only; stall_count unchanged.
- Memory wait: mem_req=1 with mem_ready low 3 cycles, then high → all enables 0 for 3 cycles, then 1; stall_count=3; mem_timeout=0.
- Timeout: MAX_WAIT=4, mem_ready low 6 cycles → mem_timeout=1 from the cycle after wait_cnt reaches 4, stays 1 after mem_ready, clears only on rst.
